// File: rtl/encoder.sv
// 8-to-3 encoder with a combinational code and registered code/valid/error.
// Build option ENCODER_PRIORITY_EN selects a priority encoder instead of the OR encoder.
module encoder #(
    parameter bit STICKY_ERR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e0,
    input  logic       e1,
    input  logic       e2,
    input  logic       e3,
    input  logic       e4,
    input  logic       e5,
    input  logic       e6,
    input  logic       e7,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] code_q,
    output logic       valid_q,
    output logic       err_q
);

    logic [7:0] e;
    logic [2:0] code;
    logic [3:0] ones;
    logic       one_hot;
    logic       err_next;

    assign e = {e7, e6, e5, e4, e3, e2, e1, e0};

`ifdef ENCODER_PRIORITY_EN
    // Highest active index wins; later loop iterations overwrite lower ones.
    always_comb begin
        code = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) begin
                code = 3'(k);
            end
        end
    end
`else
    // Code bit gi is the OR of every request whose index has bit gi set.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bit
            logic [7:0] mask;
            for (genvar gk = 0; gk < 8; gk++) begin : g_line
                localparam int SEL = (gk >> gi) & 1;
                assign mask[gk] = (SEL != 0) ? e[gk] : 1'b0;
            end
            assign code[gi] = |mask;
        end
    endgenerate
`endif

    assign a = code[2];
    assign b = code[1];
    assign c = code[0];

    always_comb begin
        ones = 4'd0;
        for (int k = 0; k < 8; k++) begin
            ones = ones + 4'(e[k]);
        end
    end

    assign one_hot  = (ones == 4'd1);
    assign err_next = STICKY_ERR ? (err_q | ~one_hot) : ~one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= 3'b000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            code_q  <= code;
            valid_q <= |e;
            err_q   <= err_next;
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder: one plain-error and one sticky-error instance share the inputs.
module tb_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] e;
    logic       a0, b0, c0, v0, er0;
    logic       a1, b1, c1, v1, er1;
    logic [2:0] q0, q1;
    int         n_vec;
    int         n_err;

    encoder #(.STICKY_ERR(1'b0)) dut_plain (
        .clk(clk), .rst_n(rst_n),
        .e0(e[0]), .e1(e[1]), .e2(e[2]), .e3(e[3]),
        .e4(e[4]), .e5(e[5]), .e6(e[6]), .e7(e[7]),
        .a(a0), .b(b0), .c(c0),
        .code_q(q0), .valid_q(v0), .err_q(er0)
    );

    encoder #(.STICKY_ERR(1'b1)) dut_sticky (
        .clk(clk), .rst_n(rst_n),
        .e0(e[0]), .e1(e[1]), .e2(e[2]), .e3(e[3]),
        .e4(e[4]), .e5(e[5]), .e6(e[6]), .e7(e[7]),
        .a(a1), .b(b1), .c(c1),
        .code_q(q1), .valid_q(v1), .err_q(er1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    endtask

    // Registered outputs of both instances packed as {code, valid, err}
    function automatic logic [7:0] regs0();
        return {3'b000, q0, v0, er0};
    endfunction
    function automatic logic [7:0] regs1();
        return {3'b000, q1, v1, er1};
    endfunction

    logic [2:0] exp_multi25;
    logic [2:0] exp_multi12;

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef ENCODER_PRIORITY_EN
        exp_multi25 = 3'b101;
        exp_multi12 = 3'b010;
`else
        exp_multi25 = 3'b111;
        exp_multi12 = 3'b011;
`endif
        rst_n = 1'b0;
        e     = 8'h00;
        #2;
        check("reset_plain_regs",  regs0(), 8'h00);
        check("reset_sticky_regs", regs1(), 8'h00);
        check("zero_abc",          {5'd0, a0, b0, c0}, 8'h00);

        // One-hot sweep with irregular hold times; regs stay cleared while reset is low
        for (int k = 0; k < 8; k++) begin
            e = 8'h01 << k;
            #(k % 7 + 1);
            check($sformatf("sweep_e%0d_abc", k), {5'd0, a0, b0, c0}, 8'(k));
        end
        check("hold_in_reset_plain",  regs0(), 8'h00);
        check("hold_in_reset_sticky", regs1(), 8'h00);

        // First capture on the first rising edge after release
        @(negedge clk);
        e     = 8'h20;
        rst_n = 1'b1;
        @(negedge clk);
        check("e5_plain_regs",  regs0(), {3'b000, 3'b101, 1'b1, 1'b0});
        check("e5_sticky_regs", regs1(), {3'b000, 3'b101, 1'b1, 1'b0});

        // All inputs low
        e = 8'h00;
        #1;
        check("allzero_abc", {5'd0, a0, b0, c0}, 8'h00);
        @(negedge clk);
        check("allzero_plain_regs",  regs0(), {3'b000, 3'b000, 1'b0, 1'b1});
        check("allzero_sticky_regs", regs1(), {3'b000, 3'b000, 1'b0, 1'b1});

        // Multi-hot e2+e5
        e = 8'h24;
        #1;
        check("e2e5_abc", {5'd0, a0, b0, c0}, {5'd0, exp_multi25});
        @(negedge clk);
        check("e2e5_plain_regs", regs0(), {3'b000, exp_multi25, 1'b1, 1'b1});

        // e6 held: plain error clears, sticky error stays
        e = 8'h40;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("e6_plain_c%0d", n),  regs0(), {3'b000, 3'b110, 1'b1, 1'b0});
            check($sformatf("e6_sticky_c%0d", n), regs1(), {3'b000, 3'b110, 1'b1, 1'b1});
        end

        // Reset pulse clears the sticky error; combinational path untouched
        rst_n = 1'b0;
        #1;
        check("pulse_sticky_regs", regs1(), 8'h00);
        check("pulse_abc_sticky",  {5'd0, a1, b1, c1}, 8'h06);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_pulse_sticky", regs1(), {3'b000, 3'b110, 1'b1, 1'b0});

        // Asynchronous reset between edges with e7 high
        e = 8'h80;
        @(negedge clk);
        check("e7_plain_regs", regs0(), {3'b000, 3'b111, 1'b1, 1'b0});
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_plain_regs",  regs0(), 8'h00);
        check("async_sticky_regs", regs1(), 8'h00);
        check("async_abc",         {5'd0, a0, b0, c0}, 8'h07);
        @(negedge clk);
        rst_n = 1'b1;

        // Multi-hot e1+e2
        e = 8'h06;
        #1;
        check("e1e2_abc", {5'd0, a1, b1, c1}, {5'd0, exp_multi12});
        @(negedge clk);
        check("e1e2_sticky_regs", regs1(), {3'b000, exp_multi12, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
